measurement_unit: RTL and testbench

- Readout stage directly downstream of the quantum engine. It runs after the engine raises done.
- Sweeps the final state vector through the state BRAM read port and computes |amplitude|^2 per basis state.
- Accumulates a running cumulative probability and samples one measured basis state by comparing the CDF against a random threshold.
- Also reports the total norm, with an error flag, so software can check for numerical drift.

---
 rtl/measurement_unit.sv | 203 ++++++++++++++++++++
 tb/tb_measurement_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/measurement_unit.sv
// measurement_unit
//   Readout stage behind the quantum engine. It sweeps the final state vector
//   through the state BRAM read port and forms |amp|^2 for each basis state.
//   It samples one basis state by comparing the running CDF against a random
//   threshold T, and it reports the total norm with a drift flag.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         single-cycle measurement request (honoured in IDLE only)
//   rand_in       16-bit unsigned fraction used as threshold T
//   rd_en/rd_addr BRAM read port; rd_data arrives one cycle after rd_en
//   rd_data       {re[31:16], im[15:0]}, signed Q2.14
//   busy          high from the cycle after start until meas_valid, inclusive
//   meas_valid    one-cycle result strobe; results hold until the next start
//   meas_outcome  measured basis index
//   meas_prob     probability of meas_outcome, Q4.28
//   norm_total    sum of all probabilities, Q.28
//   norm_err      |norm_total - 2^28| > NORM_TOL
//
// Build option: define MEAS_LFSR_EN to take T from an internal 16-bit LFSR
// (x^16+x^14+x^13+x^11+1, seed 16'hACE1) instead of rand_in.
module measurement_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int N_QUBITS   = 4,
    parameter int ACC_WIDTH  = 40,
    parameter int NORM_TOL   = 262144
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           rand_in,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_data,
    output logic                  busy,
    output logic                  meas_valid,
    output logic [ADDR_WIDTH-1:0] meas_outcome,
    output logic [31:0]           meas_prob,
    output logic [ACC_WIDTH-1:0]  norm_total,
    output logic                  norm_err
);

    localparam logic [ACC_WIDTH-1:0] ONE_Q28 = ACC_WIDTH'(64'd1 << 28);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [N_QUBITS-1:0]   cnt;
    logic                  accept;

    logic                  vld_p0, vld_p1;
    logic [N_QUBITS-1:0]   idx_p0, idx_p1;
    logic [31:0]           p_p1;

    logic [ACC_WIDTH-1:0]  acc, acc_nxt, thr;
    logic                  found, hit;
    logic [N_QUBITS-1:0]   hit_idx, last_nz;
    logic [31:0]           hit_p, last_p;

    // |re|^2 + |im|^2. Each signed square is non-negative and fits in 31 bits,
    // so the sum fits in 33 bits; legal amplitudes stay within 32.
    function automatic logic [31:0] sq_mag(input logic [31:0] d);
        logic signed [15:0] re, im;
        logic signed [31:0] rr, ii;
        logic [32:0]        s;
        re = d[31:16];
        im = d[15:0];
        rr = re * re;
        ii = im * im;
        s  = {1'b0, rr} + {1'b0, ii};
        return s[31:0];
    endfunction

    // Full-width distance of the norm from 1.0 (Q.28).
    function automatic logic norm_off(input logic [ACC_WIDTH-1:0] a);
        logic [ACC_WIDTH-1:0] d;
        d = (a >= ONE_Q28) ? (a - ONE_Q28) : (ONE_Q28 - a);
        return d > ACC_WIDTH'(NORM_TOL);
    endfunction

    assign accept  = (state == S_IDLE) && start;
    assign acc_nxt = acc + ACC_WIDTH'(p_p1);
    assign hit     = vld_p1 && !found && (acc_nxt > thr);

`ifdef MEAS_LFSR_EN
    logic [15:0] lfsr;
    logic        unused_rand;
    assign unused_rand = ^rand_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SWEEP;
            S_SWEEP: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_WIDTH'(cnt);
                if (cnt == '1) state_nxt = S_DRAIN;
            end
            // cnt wraps to 0 on entry, so bit 0 marks the second drain cycle.
            S_DRAIN: if (cnt[0]) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                       cnt <= '0;
        else if (accept)                               cnt <= '0;
        else if (state == S_SWEEP || state == S_DRAIN) cnt <= cnt + 1'b1;
    end

    // Stage 0 -> 1: BRAM data arrives one cycle after the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        idx_p0 <= cnt;
        idx_p1 <= idx_p0;
        p_p1   <= sq_mag(rd_data);
    end

    // Stage 2: accumulate the CDF and track the first crossing and last non-zero.
    always_ff @(posedge clk) begin
        if (accept) begin
`ifdef MEAS_LFSR_EN
            thr <= ACC_WIDTH'({lfsr, 12'b0});
`else
            thr <= ACC_WIDTH'({rand_in, 12'b0});
`endif
            acc     <= '0;
            hit_idx <= '0;
            hit_p   <= '0;
            last_nz <= '0;
            last_p  <= '0;
        end else if (vld_p1) begin
            acc <= acc_nxt;
            if (hit) begin
                hit_idx <= idx_p1;
                hit_p   <= p_p1;
            end
            if (p_p1 != '0) begin
                last_nz <= idx_p1;
                last_p  <= p_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            found        <= 1'b0;
            busy         <= 1'b0;
            meas_valid   <= 1'b0;
            meas_outcome <= '0;
            meas_prob    <= '0;
            norm_total   <= '0;
            norm_err     <= 1'b0;
`ifdef MEAS_LFSR_EN
            lfsr         <= 16'hACE1;
`endif
        end else begin
            meas_valid <= 1'b0;
            if (accept) begin
                found        <= 1'b0;
                busy         <= 1'b1;
                meas_outcome <= '0;
                meas_prob    <= '0;
                norm_total   <= '0;
                norm_err     <= 1'b0;
`ifdef MEAS_LFSR_EN
                lfsr         <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
            end else begin
                if (hit) found <= 1'b1;
                if (meas_valid) busy <= 1'b0;
                // Rounding can leave the CDF just below T; fall back to the
                // last non-zero state so a result is always produced.
                if (state == S_DONE) begin
                    meas_valid   <= 1'b1;
                    meas_outcome <= ADDR_WIDTH'(found ? hit_idx : last_nz);
                    meas_prob    <= found ? hit_p : last_p;
                    norm_total   <= acc;
                    norm_err     <= norm_off(acc);
                end
            end
        end
    end

endmodule

// File: tb/tb_measurement_unit.sv
module tb_measurement_unit;

    localparam int AW = 10;
    localparam int AC = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   rand_in = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data = '0;
    logic          busy, meas_valid, norm_err;
    logic [AW-1:0] meas_outcome;
    logic [31:0]   meas_prob;
    logic [AC-1:0] norm_total;

    logic [31:0]   mem [0:1023];
    int            n_chk = 0, n_pass = 0;
    int            exp_addr = 0, rd_cnt = 0, addr_err = 0;

    measurement_unit #(.ADDR_WIDTH(AW), .N_QUBITS(4), .ACC_WIDTH(AC), .NORM_TOL(262144)) dut (
        .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .meas_valid(meas_valid), .meas_outcome(meas_outcome),
        .meas_prob(meas_prob), .norm_total(norm_total), .norm_err(norm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_addr !== AW'(exp_addr)) addr_err++;
            exp_addr++;
            rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = (i < 16) ? v : 32'h0;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic meas_case(input string tag, input logic [15:0] r, input int restart_at,
                             input logic [63:0] e_out, input logic [63:0] e_prob,
                             input logic [63:0] e_norm, input logic e_err);
        int lat, busy_bad;
        @(negedge clk);
        exp_addr = 0; rd_cnt = 0; addr_err = 0;
        rand_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rand_in = 16'h0;
        lat = 0;
        busy_bad = busy ? 0 : 1;
        while (!meas_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!busy) busy_bad++;
            start = (lat == restart_at);
        end
        start = 1'b0;
        check({tag, ".latency"}, lat, 19);
        check({tag, ".busy"}, busy_bad, 0);
        check({tag, ".rd_cnt"}, rd_cnt, 16);
        check({tag, ".rd_addr_seq"}, addr_err, 0);
        check({tag, ".outcome"}, meas_outcome, e_out);
        check({tag, ".prob"}, meas_prob, e_prob);
        check({tag, ".norm"}, norm_total, e_norm);
        check({tag, ".norm_err"}, norm_err, e_err);
        @(posedge clk); #1;
        check({tag, ".valid_pulse"}, meas_valid, 0);
        check({tag, ".busy_fall"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".held"}, meas_outcome, e_out);
    endtask

    initial begin
        logic [15:0] l;
        fill(32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst.rd_en", rd_en, 0);
        check("rst.busy", busy, 0);
        check("rst.valid", meas_valid, 0);
        check("rst.outcome", meas_outcome, 0);
        check("rst.norm_err", norm_err, 0);
        @(negedge clk) rst = 1'b0;

`ifndef MEAS_LFSR_EN
        fill({16'sd16384, 16'sd0});
        for (int i = 1; i < 16; i++) mem[i] = 32'h0;
        meas_case("ket0", 16'hFFFF, -1, 0, 64'd268435456, 64'd268435456, 1'b0);

        fill({16'sd4096, 16'sd0});
        meas_case("unif_half", 16'h8000, 5, 8, 64'd16777216, 64'd268435456, 1'b0);
        meas_case("unif_zero", 16'h0000, -1, 0, 64'd16777216, 64'd268435456, 1'b0);

        fill(32'h0);
        mem[0]  = {16'sd11585, 16'sd0};
        mem[15] = {16'sd11585, 16'sd0};
        meas_case("bell", 16'h8000, -1, 15, 64'd134212225, 64'd268424450, 1'b0);

        fill(32'h0);
        meas_case("zero_vec", 16'h0000, -1, 0, 0, 0, 1'b1);

        // Abort a sweep with reset, then run a fresh measurement.
        fill({16'sd4096, 16'sd0});
        @(negedge clk) start = 1'b1; rand_in = 16'h8000;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.rd_en", rd_en, 0);
        check("midrst.busy", busy, 0);
        check("midrst.valid", meas_valid, 0);
        check("midrst.outcome", meas_outcome, 0);
        check("midrst.prob", meas_prob, 0);
        check("midrst.norm", norm_total, 0);
        check("midrst.norm_err", norm_err, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        fill(32'h0);
        mem[0]  = {16'sd11585, 16'sd0};
        mem[15] = {16'sd11585, 16'sd0};
        meas_case("after_rst", 16'h8000, -1, 15, 64'd134212225, 64'd268424450, 1'b0);
`else
        fill({16'sd4096, 16'sd0});
        l = 16'hACE1;
        meas_case("lfsr0", 16'h0000, -1, 10, 64'd16777216, 64'd268435456, 1'b0);
        l = lfsr_step(l);
        meas_case("lfsr1", 16'h0000, -1, 64'(l >> 12), 64'd16777216, 64'd268435456, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
